// File: rtl/pc_ctrl_pkg.sv
// Shared types and default constants for the program-counter controller.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun,
    StWait,
    StHalt
  } state_e;

  localparam logic [31:0] DefResetAddr = 32'h0000_0000;
  localparam logic [31:0] DefImemLimit = 32'h0000_4000;
  localparam int unsigned DefStep      = 4;

endpackage

// File: rtl/pc_incr.sv
// Sequential-fetch incrementer: pc + STEP, wrapping modulo 2^ADDR_W.
module pc_incr
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned STEP   = DefStep
) (
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus
);

  assign pc_plus = pc + ADDR_W'(STEP);

endmodule

// File: rtl/pc_ctrl.sv
// Program counter and fetch-request controller with trap/jump redirect and end-of-range halt.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(DefResetAddr),
  // One bit wider than the PC so the limit can sit just past the top of the address space.
  parameter logic [ADDR_W:0]   IMEM_LIMIT = (ADDR_W+1)'(DefImemLimit),
  parameter int unsigned       STEP       = DefStep
) (
  input  logic              ip_clk,
  input  logic              ip_rst,
  input  logic              ip_stall_ctrl,
  input  logic              ip_fetch_ready,
  input  logic              ip_jump_branch_ctrl,
  input  logic [ADDR_W-1:0] ip_target_addr,
  input  logic              ip_trap_ctrl,
  input  logic [ADDR_W-1:0] ip_trap_addr,
  output logic [ADDR_W-1:0] op_pc,
  output logic              op_fetch_valid,
  output logic              op_redirect,
  output logic              op_misalign_ctrl,
  output logic [31:0]       op_fetch_cnt,
  output logic              op_done_execute_ctrl
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus, sel_tgt;
  logic [31:0]       cnt_q, cnt_d;
  logic              redirect_q, misalign_q;
  logic              redirect, transfer, in_range;

  pc_incr #(
    .ADDR_W (ADDR_W),
    .STEP   (STEP)
  ) u_pc_incr (
    .pc      (pc_q),
    .pc_plus (pc_plus)
  );

  assign in_range = {1'b0, pc_q} < IMEM_LIMIT;
  assign redirect = ip_trap_ctrl | ip_jump_branch_ctrl;
  // Trap wins over a simultaneous jump.
  assign sel_tgt  = ip_trap_ctrl ? ip_trap_addr : ip_target_addr;
  assign transfer = op_fetch_valid & ip_fetch_ready & ~ip_stall_ctrl & ~redirect;

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = {sel_tgt[ADDR_W-1:2], 2'b00};
    end else if (transfer) begin
      pc_d = pc_plus;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (transfer && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // State register.
  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; halting looks at the next PC so HALT coincides with the out-of-range PC.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = StRun;
    end else if ({1'b0, pc_d} >= IMEM_LIMIT) begin
      state_d = StHalt;
    end else begin
      case (state_q)
        StRun:   if (op_fetch_valid && (ip_stall_ctrl || !ip_fetch_ready)) state_d = StWait;
        StWait:  if (transfer) state_d = StRun;
        StHalt:  state_d = StHalt;
        default: state_d = StRun;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    op_fetch_valid       = (state_q != StHalt) && in_range;
    op_done_execute_ctrl = (state_q == StHalt);
  end

  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      pc_q       <= RESET_ADDR;
      cnt_q      <= 32'd0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      redirect_q <= redirect;
      misalign_q <= redirect && (sel_tgt[1:0] != 2'b00);
    end
  end

  assign op_pc            = pc_q;
  assign op_fetch_cnt     = cnt_q;
  assign op_redirect      = redirect_q;
  assign op_misalign_ctrl = misalign_q;

endmodule
